// File: rtl/regfile_wb_if.sv
// Bundle of ALU, long-latency, issue, scoreboard and register-file write-port signals for regfile_wb.
// Forwarding signals are present only when REGFILE_WB_FORWARD_EN is defined.
`timescale 1ns/1ps
interface regfile_wb_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 3
);
  logic                   a_valid;
  logic [AWIDTH-1:0]      a_sel;
  logic [DWIDTH-1:0]      a_data;
  logic                   l_valid;
  logic                   l_ready;
  logic [AWIDTH-1:0]      l_sel;
  logic [DWIDTH-1:0]      l_data;
  logic                   iss_valid;
  logic [AWIDTH-1:0]      iss_sel;
  logic [2**AWIDTH-1:0]   busy;
  logic                   sb_err;
  logic                   we;
  logic [AWIDTH-1:0]      wsel;
  logic [DWIDTH-1:0]      wdata;
`ifdef REGFILE_WB_FORWARD_EN
  logic [AWIDTH-1:0]      fwd_sel;
  logic                   fwd_hit;
  logic [DWIDTH-1:0]      fwd_data;
`endif

  modport master (
    output a_valid, a_sel, a_data, l_valid, l_sel, l_data, iss_valid, iss_sel,
`ifdef REGFILE_WB_FORWARD_EN
    output fwd_sel,
    input  fwd_hit, fwd_data,
`endif
    input  l_ready, busy, sb_err, we, wsel, wdata
  );

  modport slave (
    input  a_valid, a_sel, a_data, l_valid, l_sel, l_data, iss_valid, iss_sel,
`ifdef REGFILE_WB_FORWARD_EN
    input  fwd_sel,
    output fwd_hit, fwd_data,
`endif
    output l_ready, busy, sb_err, we, wsel, wdata
  );
endinterface

// File: rtl/regfile_wb.sv
// Write-back merge: ALU results (1 cycle, top priority) and FIFO-buffered long-latency results (>=2 cycles,
// l_ready = !full) onto one regfile write port, with a busy scoreboard. REGFILE_WB_FORWARD_EN adds a commit bypass.
`timescale 1ns/1ps
module regfile_wb #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 3,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_wb_if.slave bus
);
  localparam int            NREG     = 2**AWIDTH;
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [AWIDTH-1:0] sel;
    logic [DWIDTH-1:0] dat;
  } entry_t;

  entry_t              mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         count;
  logic                push;
  logic                pop;
  logic                commit;
  logic                err_now;
  logic [NREG-1:0]     set_vec;
  logic [NREG-1:0]     clr_vec;
  logic                we_q;
  logic                src_l;
  logic [AWIDTH-1:0]   wsel_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [NREG-1:0]     busy_q;
  logic                err_q;

  // Ready comes from the registered count only; a full FIFO popping this cycle still refuses.
  assign bus.l_ready = (count != FULL_CNT);
  assign push        = bus.l_valid && bus.l_ready;
  assign pop         = !bus.a_valid && (count != '0);
  assign commit      = we_q && src_l;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (bus.iss_valid) set_vec[bus.iss_sel] = 1'b1;
    if (commit)        clr_vec[wsel_q]      = 1'b1;
  end

  assign err_now = (bus.iss_valid && busy_q[bus.iss_sel] && !clr_vec[bus.iss_sel]) ||
                   (commit && !busy_q[wsel_q]);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{sel: bus.l_sel, dat: bus.l_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      we_q    <= 1'b0;
      src_l   <= 1'b0;
      wsel_q  <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase

      if (bus.a_valid) begin
        we_q    <= 1'b1;
        src_l   <= 1'b0;
        wsel_q  <= bus.a_sel;
        wdata_q <= bus.a_data;
      end else if (pop) begin
        we_q    <= 1'b1;
        src_l   <= 1'b1;
        wsel_q  <= mem[rd_ptr].sel;
        wdata_q <= mem[rd_ptr].dat;
      end else begin
        we_q    <= 1'b0;
        src_l   <= 1'b0;
      end

      // Set is applied after clear so a same-edge reissue keeps the register busy.
      busy_q <= (busy_q & ~clr_vec) | set_vec;
      if (err_now) err_q <= 1'b1;
    end
  end

  assign bus.we     = we_q;
  assign bus.wsel   = wsel_q;
  assign bus.wdata  = wdata_q;
  assign bus.busy   = busy_q;
  assign bus.sb_err = err_q;

`ifdef REGFILE_WB_FORWARD_EN
  assign bus.fwd_hit  = we_q && (wsel_q == bus.fwd_sel);
  assign bus.fwd_data = wdata_q;
`endif
endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed scenarios plus randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_regfile_wb;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  regfile_wb_if #(.DWIDTH(DW), .AWIDTH(AW)) bif ();
  regfile_wb #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.a_valid = 1'b0; bif.a_sel = '0; bif.a_data = '0;
    bif.l_valid = 1'b0; bif.l_sel = '0; bif.l_data = '0;
    bif.iss_valid = 1'b0; bif.iss_sel = '0;
`ifdef REGFILE_WB_FORWARD_EN
    bif.fwd_sel = '0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.a_valid = 1'b1; bif.a_sel = 3'd6; bif.a_data = 16'hFFFF;
    bif.l_valid = 1'b1; bif.iss_valid = 1'b1; bif.iss_sel = 3'd1;
    cyc(); cyc();
    total++;
    if ({bif.we, bif.wsel, bif.wdata} !== {1'b0, 3'd0, 16'h0}) begin
      bad++; $display("FAIL reset_wport got=%h want=0", {bif.we, bif.wsel, bif.wdata});
    end
    total++;
    if ({bif.busy, bif.sb_err, bif.l_ready} !== {8'h00, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_sb got busy=%h err=%b rdy=%b want 00/0/1", bif.busy, bif.sb_err, bif.l_ready);
    end
    idle();
    rst_n = 1'b1;
    cyc();
    total++;
    if ({bif.we, bif.l_ready} !== 2'b01) begin
      bad++; $display("FAIL reset_release got we=%b rdy=%b want 0/1", bif.we, bif.l_ready);
    end
  endtask

  task automatic test_alu_write();
    bif.a_valid = 1'b1; bif.a_sel = 3'd3; bif.a_data = 16'h1234;
    cyc();
    bif.a_valid = 1'b0;
    total++;
    if ({bif.we, bif.wsel, bif.wdata} !== {1'b1, 3'd3, 16'h1234}) begin
      bad++; $display("FAIL alu_write got=%h want=%h", {bif.we, bif.wsel, bif.wdata}, {1'b1, 3'd3, 16'h1234});
    end
    cyc();
    total++;
    if ({bif.we, bif.wsel, bif.wdata} !== {1'b0, 3'd3, 16'h1234}) begin
      bad++; $display("FAIL alu_hold got=%h want=%h", {bif.we, bif.wsel, bif.wdata}, {1'b0, 3'd3, 16'h1234});
    end
  endtask

  task automatic test_load_path();
    bif.iss_valid = 1'b1; bif.iss_sel = 3'd5;
    cyc();
    bif.iss_valid = 1'b0;
    total++;
    if (bif.busy !== 8'h20) begin
      bad++; $display("FAIL load_busy_set got=%h want=20", bif.busy);
    end
    bif.l_valid = 1'b1; bif.l_sel = 3'd5; bif.l_data = 16'hBEEF;
    cyc();
    bif.l_valid = 1'b0;
    total++;
    if (bif.we !== 1'b0) begin
      bad++; $display("FAIL load_min_latency got we=%b want 0", bif.we);
    end
    cyc();
    total++;
    if ({bif.we, bif.wsel, bif.wdata, bif.busy} !== {1'b1, 3'd5, 16'hBEEF, 8'h20}) begin
      bad++; $display("FAIL load_commit got=%h want=%h", {bif.we, bif.wsel, bif.wdata, bif.busy}, {1'b1, 3'd5, 16'hBEEF, 8'h20});
    end
    cyc();
    total++;
    if ({bif.we, bif.busy, bif.sb_err} !== {1'b0, 8'h00, 1'b0}) begin
      bad++; $display("FAIL load_busy_clear got we=%b busy=%h err=%b want 0/00/0", bif.we, bif.busy, bif.sb_err);
    end
  endtask

  task automatic test_priority();
    logic [2:0]  ks;
    logic [15:0] kd;
    bif.iss_valid = 1'b1; bif.iss_sel = 3'd1; cyc();
    bif.iss_sel = 3'd6; cyc();
    bif.iss_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ks = 3'(k);
      kd = 16'hA000 + 16'(k);
      bif.a_valid = 1'b1; bif.a_sel = ks; bif.a_data = kd;
      bif.l_valid = (k < 2); bif.l_sel = (k == 0) ? 3'd1 : 3'd6; bif.l_data = 16'(k + 1);
      cyc();
      total++;
      if ({bif.we, bif.wsel, bif.wdata, bif.l_ready} !== {1'b1, ks, kd, (k == 0)}) begin
        bad++; $display("FAIL prio_a%0d got=%h want=%h", k, {bif.we, bif.wsel, bif.wdata, bif.l_ready}, {1'b1, ks, kd, (k == 0)});
      end
    end
    idle();
    cyc();
    total++;
    if ({bif.we, bif.wsel, bif.wdata, bif.l_ready} !== {1'b1, 3'd1, 16'h0001, 1'b1}) begin
      bad++; $display("FAIL prio_l1 got=%h want=%h", {bif.we, bif.wsel, bif.wdata, bif.l_ready}, {1'b1, 3'd1, 16'h0001, 1'b1});
    end
    cyc();
    total++;
    if ({bif.we, bif.wsel, bif.wdata, bif.busy} !== {1'b1, 3'd6, 16'h0002, 8'h40}) begin
      bad++; $display("FAIL prio_l2 got=%h want=%h", {bif.we, bif.wsel, bif.wdata, bif.busy}, {1'b1, 3'd6, 16'h0002, 8'h40});
    end
    cyc();
    total++;
    if ({bif.we, bif.busy, bif.sb_err} !== {1'b0, 8'h00, 1'b0}) begin
      bad++; $display("FAIL prio_drain got we=%b busy=%h err=%b want 0/00/0", bif.we, bif.busy, bif.sb_err);
    end
  endtask

  task automatic test_scoreboard();
    bif.iss_valid = 1'b1; bif.iss_sel = 3'd2; cyc();
    bif.iss_valid = 1'b0;
    bif.l_valid = 1'b1; bif.l_sel = 3'd2; bif.l_data = 16'h5A5A; cyc();
    bif.l_valid = 1'b0; cyc();
    total++;
    if ({bif.we, bif.wsel, bif.wdata} !== {1'b1, 3'd2, 16'h5A5A}) begin
      bad++; $display("FAIL sb_commit got=%h want=%h", {bif.we, bif.wsel, bif.wdata}, {1'b1, 3'd2, 16'h5A5A});
    end
    bif.iss_valid = 1'b1; bif.iss_sel = 3'd2; cyc();
    total++;
    if ({bif.busy, bif.sb_err} !== {8'h04, 1'b0}) begin
      bad++; $display("FAIL sb_set_wins got busy=%h err=%b want 04/0", bif.busy, bif.sb_err);
    end
    cyc();
    bif.iss_valid = 1'b0;
    total++;
    if (bif.sb_err !== 1'b1) begin
      bad++; $display("FAIL sb_double_issue got err=%b want 1", bif.sb_err);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (bif.sb_err !== 1'b1) begin
        bad++; $display("FAIL sb_sticky%0d got err=%b want 1", i, bif.sb_err);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bif.iss_valid = 1'b1; bif.iss_sel = 3'd3; cyc();
    bif.iss_valid = 1'b0;
    bif.a_valid = 1'b1; bif.a_sel = 3'd0; bif.a_data = 16'h0;
    bif.l_valid = 1'b1; bif.l_sel = 3'd2; bif.l_data = 16'h1111; cyc();
    bif.l_sel = 3'd3; bif.l_data = 16'h2222; cyc();
    total++;
    if ({bif.l_ready, bif.busy} !== {1'b0, 8'h0C}) begin
      bad++; $display("FAIL mid_setup got rdy=%b busy=%h want 0/0c", bif.l_ready, bif.busy);
    end
    rst_n = 1'b0;
    bif.iss_valid = 1'b1; bif.iss_sel = 3'd7;
    cyc();
    total++;
    if ({bif.we, bif.wsel, bif.wdata, bif.busy, bif.sb_err, bif.l_ready} !== {1'b0, 3'd0, 16'h0, 8'h00, 1'b0, 1'b1}) begin
      bad++; $display("FAIL mid_reset got we=%b sel=%h d=%h busy=%h err=%b rdy=%b", bif.we, bif.wsel, bif.wdata, bif.busy, bif.sb_err, bif.l_ready);
    end
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if ({bif.we, bif.busy} !== {1'b0, 8'h00}) begin
        bad++; $display("FAIL mid_no_stale%0d got we=%b busy=%h want 0/00", i, bif.we, bif.busy);
      end
    end
  endtask

`ifdef REGFILE_WB_FORWARD_EN
  task automatic test_forward();
    bif.a_valid = 1'b1; bif.a_sel = 3'd3; bif.a_data = 16'h1234;
    cyc();
    bif.a_valid = 1'b0;
    bif.fwd_sel = 3'd3; #1;
    total++;
    if ({bif.fwd_hit, bif.fwd_data} !== {1'b1, 16'h1234}) begin
      bad++; $display("FAIL fwd_hit got=%h want=%h", {bif.fwd_hit, bif.fwd_data}, {1'b1, 16'h1234});
    end
    bif.fwd_sel = 3'd4; #1;
    total++;
    if (bif.fwd_hit !== 1'b0) begin
      bad++; $display("FAIL fwd_miss got=%b want 0", bif.fwd_hit);
    end
    cyc();
  endtask
`endif

  // Reference: a FIFO queue of pending results, a busy bit array and the last write-port value.
  task automatic test_random();
    logic [18:0] q[$];
    int          pend[$];
    logic        m_we, m_src, m_err, commit, ready;
    logic [2:0]  m_sel;
    logic [15:0] m_dat;
    logic [7:0]  m_busy, nb;
    logic [18:0] e;
    int          r;
    rst_n = 1'b0; idle(); cyc();
    rst_n = 1'b1;
    m_we = 0; m_src = 0; m_err = 0; m_sel = 0; m_dat = 0; m_busy = 0;
    for (int n = 0; n < 400; n++) begin
      bif.a_valid = ($urandom_range(0, 9) < 4);
      bif.a_sel = 3'($urandom); bif.a_data = 16'($urandom);
      r = $urandom_range(0, 7);
      bif.iss_valid = ($urandom_range(0, 9) < 3) && !m_busy[r];
      bif.iss_sel = 3'(r);
      bif.l_valid = (pend.size() > 0) && ($urandom_range(0, 9) < 6);
      bif.l_sel = (pend.size() > 0) ? 3'(pend[0]) : 3'd0;
      bif.l_data = 16'($urandom);

      ready = (q.size() < DEPTH);
      commit = m_we && m_src;
      if (bif.iss_valid && m_busy[r] && !(commit && m_sel == 3'(r))) m_err = 1;
      if (commit && !m_busy[m_sel]) m_err = 1;
      nb = m_busy;
      if (commit) nb[m_sel] = 1'b0;
      if (bif.iss_valid) nb[r] = 1'b1;
      m_busy = nb;
      if (bif.a_valid) begin
        m_we = 1; m_src = 0; m_sel = bif.a_sel; m_dat = bif.a_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_we = 1; m_src = 1; m_sel = e[18:16]; m_dat = e[15:0];
      end else begin
        m_we = 0; m_src = 0;
      end
      if (bif.l_valid && ready) begin
        q.push_back({bif.l_sel, bif.l_data});
        void'(pend.pop_front());
      end
      if (bif.iss_valid) pend.push_back(r);

      cyc();
      total++;
      if ({bif.we, bif.wsel, bif.wdata} !== {m_we, m_sel, m_dat}) begin
        bad++; $display("FAIL rnd_wport n=%0d got=%h want=%h", n, {bif.we, bif.wsel, bif.wdata}, {m_we, m_sel, m_dat});
      end
      total++;
      if ({bif.busy, bif.sb_err, bif.l_ready} !== {m_busy, m_err, (q.size() < DEPTH)}) begin
        bad++; $display("FAIL rnd_sb n=%0d got busy=%h err=%b rdy=%b want %h/%b/%b", n, bif.busy, bif.sb_err, bif.l_ready, m_busy, m_err, (q.size() < DEPTH));
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_write();
    test_load_path();
    test_priority();
    test_scoreboard();
    test_reset_midflight();
`ifdef REGFILE_WB_FORWARD_EN
    test_forward();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Write-back stage directly upstream of the register file write port (we/wsel/wdata).
- Merges two result sources onto the single write port:
  - A: single-cycle ALU results, never stalled, highest priority.
  - L: load/long-latency results, valid/ready handshake, buffered in a small FIFO.
- Keeps a per-register busy scoreboard for outstanding long-latency ops, which issue logic uses for hazard stalls.

Parameters:
- DWIDTH, 16, data width; must match the register file.
- AWIDTH, 3, register select width; 2**AWIDTH registers.
- DEPTH, 2, L FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- a_valid  in  1  ALU result present this cycle; always accepted.
- a_sel  in  AWIDTH  ALU destination register.
- a_data  in  DWIDTH  ALU result.
- l_valid  in  1  long-latency result offered.
- l_ready  out  1  FIFO can accept; transfer on l_valid && l_ready.
- l_sel  in  AWIDTH  long-latency destination register.
- l_data  in  DWIDTH  long-latency result.
- iss_valid  in  1  long-latency op issued this cycle.
- iss_sel  in  AWIDTH  its destination register; marked busy.
- busy  out  2**AWIDTH  scoreboard; bit r=1 means a result for r is outstanding.
- sb_err  out  1  sticky scoreboard protocol error.
- we  out  1  register file write enable.
- wsel  out  AWIDTH  register file write select.
- wdata  out  DWIDTH  register file write data.

Behaviour:
- Reset (rst_n=0 at an edge):
  - we=0, wsel=0, wdata=0, busy=0, sb_err=0, FIFO emptied.
  - All inputs are ignored that cycle. Reset mid-transfer drops buffered entries.
- l_ready = !full, derived from registered count only. No same-cycle pass-through: a full FIFO deasserts l_ready even if it pops that cycle. l_ready=1 in the first cycle after reset.
- Write output registers, loaded every edge:
  - a_valid=1 in cycle N: we=1, wsel=a_sel, wdata=a_data in cycle N+1.
  - Else, if FIFO non-empty: pop head; in N+1 we=1, wsel/wdata from head, internal src_l=1.
  - Else: we=0; wsel/wdata hold their previous values.
- Latency:
  - A: 1 cycle to write port; value readable from regfile at N+2.
  - L: minimum 2 cycles (push at edge N, pop in N+1, we in N+2).
- Arbitration: strict A priority; L may starve while a_valid stays high, and upstream guarantees bubbles. FIFO order is preserved. A write to a busy register does not clear busy.
- Push and pop in the same cycle: count unchanged, pointers wrap modulo DEPTH.
- Scoreboard:
  - iss_valid sets busy[iss_sel] at the edge.
  - busy[wsel] clears at the end of a cycle with we=1 and src_l=1, i.e. the same edge the regfile writes.
  - Set and clear of the same register at the same edge: set wins.
- sb_err is set, and held until reset, on either:
  - iss_valid to a register already busy and not clearing that edge;
  - an L commit (we && src_l) to a non-busy register.
- Widths: no arithmetic on data; pointers are log2(DEPTH) bits; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro REGFILE_WB_FORWARD_EN.
- Defined: adds ports fwd_sel (in, AWIDTH), fwd_hit (out, 1) and fwd_data (out, DWIDTH), all combinational.
  - fwd_hit = we && (wsel == fwd_sel); fwd_data = wdata.
  - This exposes the value committing this cycle, before the regfile shows it.
- Undefined: the ports do not exist and no comparator is built; the rest of the behaviour is identical.

Test Plan:
- Reset, then a_valid=1, a_sel=3, a_data=16'h1234 for one cycle -> next cycle we=1, wsel=3, wdata=16'h1234; following cycle we=0.
- iss_valid with iss_sel=5 -> busy=8'h20. Later push l_sel=5, l_data=16'hBEEF with a_valid=0 -> we=1, wsel=5, wdata=16'hBEEF two cycles after push; busy=0 after that edge.
- a_valid=1 for 4 cycles while pushing L entries 16'h0001 and 16'h0002 -> l_ready=0 after second push. A writes appear first; L writes follow in order 1, 2 on consecutive cycles after a_valid drops; l_ready returns to 1.
- Same edge: iss_valid, iss_sel=2 and an L commit to register 2 -> busy[2]=1, sb_err=0. A second iss to register 2 while busy -> sb_err=1, held until rst_n=0.
- Assert rst_n=0 with 2 FIFO entries and busy=8'h0C -> next cycle we=0, busy=0, l_ready=1; no stale writes appear afterwards.
- With REGFILE_WB_FORWARD_EN: fwd_sel=3 during the cycle we=1, wsel=3, wdata=16'h1234 -> fwd_hit=1, fwd_data=16'h1234; fwd_sel=4 -> fwd_hit=0.
